// File: rtl/tlb_fence_responder_if.sv
// Fence-responder bus: flush request/operands, tag-array read port, valid-clear write port.
// The responder uses the slave modport; the TLB/fence side uses master.
interface tlb_fence_responder_if #(
   parameter int SETS       = 32,
   parameter int WAYS       = 4,
   parameter int VADDR_SIZE = 39,
   parameter int ASID_W     = 16,
   parameter int VPN_W      = VADDR_SIZE - 12,
   parameter int SET_W      = $clog2(SETS)
);
   logic                    flush_req;
   logic                    flush_all;
   logic [VADDR_SIZE-1:0]   flush_vaddr;
   logic [ASID_W-1:0]       flush_asid;
   logic                    flush_end;
   logic                    busy;
   logic                    tag_ren;
   logic [SET_W-1:0]        tag_raddr;
   logic [WAYS-1:0]         tag_valid;
   logic [WAYS-1:0]         tag_global;
   logic [WAYS*ASID_W-1:0]  tag_asid;
   logic [WAYS*VPN_W-1:0]   tag_vpn;
   logic                    valid_we;
   logic [SET_W-1:0]        valid_waddr;
   logic [WAYS-1:0]         valid_clr;

   modport slave (
      input  flush_req, flush_all, flush_vaddr, flush_asid,
      input  tag_valid, tag_global, tag_asid, tag_vpn,
      output flush_end, busy, tag_ren, tag_raddr,
      output valid_we, valid_waddr, valid_clr
   );

   modport master (
      output flush_req, flush_all, flush_vaddr, flush_asid,
      output tag_valid, tag_global, tag_asid, tag_vpn,
      input  flush_end, busy, tag_ren, tag_raddr,
      input  valid_we, valid_waddr, valid_clr
   );
endinterface

// File: rtl/tlb_fence_responder.sv
// sfence.vma responder: walks one set (address flush) or all sets (flush-all),
// clearing valid bits of matching ways, then pulses flush_end.
module tlb_fence_responder #(
   parameter int SETS       = 32,
   parameter int WAYS       = 4,
   parameter int VADDR_SIZE = 39,
   parameter int ASID_W     = 16,
   parameter int VPN_W      = VADDR_SIZE - 12
) (
   input  logic                 clk,
   input  logic                 rst,
   tlb_fence_responder_if.slave bus
);
   localparam int SET_W = $clog2(SETS);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_END} state_t;

   state_t               r_state;
   logic                 r_all;
   logic [VPN_W-1:0]     r_vpn;
   logic [ASID_W-1:0]    r_asid;
   logic [SET_W-1:0]     r_start;
   logic [SET_W:0]       r_cnt;
   logic                 r_tag_ren;
   logic [SET_W-1:0]     r_raddr;
   logic                 r_cmp_vld;
   logic [SET_W-1:0]     r_cmp_set;
   logic                 r_flush_end;
   logic [SET_W:0]       w_last;
   logic [WAYS-1:0]      w_match;
   logic                 w_unused_vaddr_lo;

   assign w_last            = r_all ? (SET_W+1)'(SETS - 1) : '0;
   assign w_unused_vaddr_lo = ^bus.flush_vaddr[11:0];

   // Tag array output is itself the read register, so the compare is pure
   // gating on it and lands in the cycle the data appears.
   always_comb begin
      w_match = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         w_match[w] = bus.tag_valid[w]
                    & (r_all | (bus.tag_vpn[w*VPN_W +: VPN_W] == r_vpn))
                    & ((r_asid == '0) |
                       (~bus.tag_global[w] & (bus.tag_asid[w*ASID_W +: ASID_W] == r_asid)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_all       <= 1'b0;
         r_vpn       <= '0;
         r_asid      <= '0;
         r_start     <= '0;
         r_cnt       <= '0;
         r_tag_ren   <= 1'b0;
         r_raddr     <= '0;
         r_cmp_vld   <= 1'b0;
         r_cmp_set   <= '0;
         r_flush_end <= 1'b0;
      end else begin
         r_cmp_vld <= r_tag_ren;
         r_cmp_set <= r_raddr;
         case (r_state)
            S_IDLE: begin
               if (bus.flush_req) begin
                  r_state   <= S_READ;
                  r_all     <= bus.flush_all;
                  r_vpn     <= bus.flush_vaddr[VADDR_SIZE-1:12];
                  r_asid    <= bus.flush_asid;
                  r_start   <= bus.flush_all ? '0 : bus.flush_vaddr[12 +: SET_W];
                  r_raddr   <= bus.flush_all ? '0 : bus.flush_vaddr[12 +: SET_W];
                  r_cnt     <= '0;
                  r_tag_ren <= 1'b1;
               end
            end
            S_READ: begin
               if (r_cnt == w_last) begin
                  r_state   <= S_DRAIN;
                  r_tag_ren <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_raddr <= r_start + SET_W'(r_cnt + 1'b1);
               end
            end
            S_DRAIN: begin
               r_state     <= S_END;
               r_flush_end <= 1'b1;
            end
            S_END: begin
               r_state     <= S_IDLE;
               r_flush_end <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = (r_state != S_IDLE) | bus.flush_req;
   assign bus.flush_end   = r_flush_end;
   assign bus.tag_ren     = r_tag_ren;
   assign bus.tag_raddr   = r_raddr;
   assign bus.valid_we    = r_cmp_vld & (|w_match);
   assign bus.valid_clr   = r_cmp_vld ? w_match : '0;
   assign bus.valid_waddr = r_cmp_set;
endmodule

// File: tb/tb_tlb_fence_responder.sv
// Randomized bench for tlb_fence_responder: a behavioural tag array plus a
// per-set expected-clear table computed from the flush rules.
module tb_tlb_fence_responder;
   localparam int SETS   = 32;
   localparam int WAYS   = 4;
   localparam int VADDR  = 39;
   localparam int ASID_W = 16;
   localparam int VPN_W  = VADDR - 12;
   localparam int SET_W  = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   tlb_fence_responder_if #(.SETS(SETS), .WAYS(WAYS), .VADDR_SIZE(VADDR), .ASID_W(ASID_W)) bus ();

   tlb_fence_responder #(.SETS(SETS), .WAYS(WAYS), .VADDR_SIZE(VADDR), .ASID_W(ASID_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic              m_valid  [SETS][WAYS];
   logic              m_global [SETS][WAYS];
   logic [ASID_W-1:0] m_asid   [SETS][WAYS];
   logic [VPN_W-1:0]  m_vpn    [SETS][WAYS];

   // Synchronous tag array: data appears the cycle after tag_ren.
   always @(posedge clk) begin
      if (bus.tag_ren) begin
         for (int w = 0; w < WAYS; w++) begin
            bus.tag_valid[w]                  <= m_valid[bus.tag_raddr][w];
            bus.tag_global[w]                 <= m_global[bus.tag_raddr][w];
            bus.tag_asid[w*ASID_W +: ASID_W]  <= m_asid[bus.tag_raddr][w];
            bus.tag_vpn[w*VPN_W +: VPN_W]     <= m_vpn[bus.tag_raddr][w];
         end
      end
   end

   task automatic fill_random(input logic [VPN_W-1:0] vt, input logic [ASID_W-1:0] at);
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w]  = ($urandom_range(0, 3) != 0);
            m_global[s][w] = ($urandom_range(0, 3) == 0);
            m_asid[s][w]   = $urandom_range(0, 1) ? at : ASID_W'($urandom_range(0, 3));
            m_vpn[s][w]    = $urandom_range(0, 1) ? vt : VPN_W'($urandom);
         end
   endtask

   task automatic fill_const(input logic v, input logic [ASID_W-1:0] a);
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w]  = v;
            m_global[s][w] = 1'b0;
            m_asid[s][w]   = a;
            m_vpn[s][w]    = VPN_W'(s + 1000);
         end
   endtask

   // Issue one flush and check every cycle of it against the reference table.
   task automatic run_flush(input logic all, input logic [VADDR-1:0] vaddr,
                            input logic [ASID_W-1:0] asid,
                            output int writes, output logic [WAYS-1:0] last_clr);
      logic [WAYS-1:0]  emask [SETS];
      logic [VPN_W-1:0] vpn;
      int               start, n, s;
      logic             e_ren, e_we;
      logic [WAYS-1:0]  e_clr;
      vpn   = vaddr[VADDR-1:12];
      start = all ? 0 : int'(vpn[SET_W-1:0]);
      n     = all ? SETS : 1;
      for (int i = 0; i < SETS; i++) begin
         emask[i] = '0;
         for (int w = 0; w < WAYS; w++)
            if (m_valid[i][w] && (all || m_vpn[i][w] == vpn) &&
                (asid == 0 || (!m_global[i][w] && m_asid[i][w] == asid)))
               emask[i][w] = 1'b1;
      end
      writes   = 0;
      last_clr = '0;
      @(negedge clk);
      bus.flush_req   = 1'b1;
      bus.flush_all   = all;
      bus.flush_vaddr = vaddr;
      bus.flush_asid  = asid;
      #1;
      vectors++;
      if (bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_req_cycle: got %b expected 1", bus.busy);
      end
      for (int k = 1; k <= n + 4; k++) begin
         @(negedge clk);
         bus.flush_req   = 1'b0;
         bus.flush_vaddr = VADDR'($urandom);
         bus.flush_asid  = ASID_W'($urandom);
         #1;
         e_ren = (k >= 1 && k <= n);
         e_clr = '0;
         s     = 0;
         if (k >= 2 && k <= n + 1) begin
            s     = (start + k - 2) % SETS;
            e_clr = emask[s];
         end
         e_we = |e_clr;
         vectors++;
         if (bus.tag_ren !== e_ren) begin
            miscompares++;
            $display("FAIL tag_ren k=%0d: got %b expected %b", k, bus.tag_ren, e_ren);
         end
         if (e_ren) begin
            vectors++;
            if (bus.tag_raddr !== SET_W'(start + k - 1)) begin
               miscompares++;
               $display("FAIL tag_raddr k=%0d: got %0d expected %0d", k, bus.tag_raddr, start + k - 1);
            end
         end
         vectors++;
         if (bus.valid_we !== e_we || bus.valid_clr !== e_clr) begin
            miscompares++;
            $display("FAIL valid_clr k=%0d: got we=%b clr=%b expected we=%b clr=%b",
                     k, bus.valid_we, bus.valid_clr, e_we, e_clr);
         end
         if (e_we) begin
            vectors++;
            if (bus.valid_waddr !== SET_W'(s)) begin
               miscompares++;
               $display("FAIL valid_waddr k=%0d: got %0d expected %0d", k, bus.valid_waddr, s);
            end
         end
         if (bus.valid_we === 1'b1) begin
            writes++;
            last_clr = bus.valid_clr;
         end
         vectors++;
         if (bus.flush_end !== (k == n + 2)) begin
            miscompares++;
            $display("FAIL flush_end k=%0d: got %b expected %b", k, bus.flush_end, k == n + 2);
         end
         vectors++;
         if (bus.busy !== (k <= n + 2)) begin
            miscompares++;
            $display("FAIL busy k=%0d: got %b expected %b", k, bus.busy, k <= n + 2);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         vectors++;
         if ({bus.flush_end, bus.busy, bus.tag_ren, bus.valid_we} !== 4'b0 ||
             bus.valid_clr !== '0 || bus.valid_waddr !== '0 || bus.tag_raddr !== '0) begin
            miscompares++;
            $display("FAIL reset_idle k=%0d: got end=%b busy=%b ren=%b we=%b clr=%b waddr=%0d raddr=%0d expected all 0",
                     k, bus.flush_end, bus.busy, bus.tag_ren, bus.valid_we, bus.valid_clr,
                     bus.valid_waddr, bus.tag_raddr);
         end
      end
   endtask

   task automatic test_single_global();
      int wr;
      logic [WAYS-1:0] clr;
      fill_const(1'b0, 16'h0);
      m_valid[3][0] = 1'b1; m_vpn[3][0] = 27'h404;
      m_valid[3][1] = 1'b1; m_vpn[3][1] = 27'h403; m_global[3][1] = 1'b1; m_asid[3][1] = 16'h22;
      m_valid[3][2] = 1'b1; m_vpn[3][2] = 27'h403; m_asid[3][2] = 16'h1;
      m_valid[3][3] = 1'b1; m_vpn[3][3] = 27'h1403;
      run_flush(1'b0, 39'h00_0040_3000, 16'h0, wr, clr);
      vectors++;
      if (wr !== 1 || clr !== 4'b0110) begin
         miscompares++;
         $display("FAIL single_global: got writes=%0d clr=%b expected 1 0110", wr, clr);
      end
   endtask

   task automatic test_single_asid();
      int wr;
      logic [WAYS-1:0] clr;
      fill_const(1'b0, 16'h0);
      m_valid[3][0] = 1'b1; m_vpn[3][0] = 27'h403; m_asid[3][0] = 16'd5;
      m_valid[3][1] = 1'b1; m_vpn[3][1] = 27'h403; m_asid[3][1] = 16'd5; m_global[3][1] = 1'b1;
      m_valid[3][2] = 1'b1; m_vpn[3][2] = 27'h403; m_asid[3][2] = 16'd7;
      run_flush(1'b0, 39'h00_0040_3000, 16'd5, wr, clr);
      vectors++;
      if (wr !== 1 || clr !== 4'b0001) begin
         miscompares++;
         $display("FAIL single_asid: got writes=%0d clr=%b expected 1 0001", wr, clr);
      end
   endtask

   task automatic test_walk_all();
      int wr;
      logic [WAYS-1:0] clr;
      fill_const(1'b1, 16'h3);
      run_flush(1'b1, 39'h0, 16'h0, wr, clr);
      vectors++;
      if (wr !== SETS || clr !== 4'b1111) begin
         miscompares++;
         $display("FAIL walk_all: got writes=%0d clr=%b expected 32 1111", wr, clr);
      end
   endtask

   task automatic test_walk_asid();
      int wr;
      logic [WAYS-1:0] clr;
      fill_const(1'b1, 16'h3);
      for (int w = 0; w < 3; w++) m_valid[10][w] = 1'b0;
      m_asid[10][3] = 16'd9;
      run_flush(1'b1, 39'h0, 16'd9, wr, clr);
      vectors++;
      if (wr !== 1 || clr !== 4'b1000) begin
         miscompares++;
         $display("FAIL walk_asid: got writes=%0d clr=%b expected 1 1000", wr, clr);
      end
   endtask

   task automatic test_reset_mid();
      int wr;
      logic [WAYS-1:0] clr;
      fill_const(1'b1, 16'h0);
      @(negedge clk);
      bus.flush_req = 1'b1;
      bus.flush_all = 1'b1;
      bus.flush_asid = 16'h0;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         bus.flush_req = 1'b0;
         rst = (k == 12);
         #1;
         if (k >= 13) begin
            vectors++;
            if ({bus.busy, bus.valid_we, bus.flush_end, bus.tag_ren} !== 4'b0) begin
               miscompares++;
               $display("FAIL reset_mid k=%0d: got busy=%b we=%b end=%b ren=%b expected all 0",
                        k, bus.busy, bus.valid_we, bus.flush_end, bus.tag_ren);
            end
         end
      end
      fill_random(VPN_W'($urandom), 16'd2);
      run_flush(1'b1, 39'h0, 16'd2, wr, clr);
   endtask

   task automatic test_random();
      int wr;
      logic [WAYS-1:0] clr;
      logic [VADDR-1:0] va;
      logic [ASID_W-1:0] as;
      logic all;
      for (int i = 0; i < 12; i++) begin
         va  = {VADDR'($urandom), 12'($urandom)};
         as  = $urandom_range(0, 2) == 0 ? 16'h0 : ASID_W'($urandom_range(1, 3));
         all = ($urandom_range(0, 2) == 0);
         fill_random(va[VADDR-1:12], as);
         run_flush(all, va, as, wr, clr);
      end
   endtask

   initial begin
      bus.flush_req   = 1'b0;
      bus.flush_all   = 1'b0;
      bus.flush_vaddr = '0;
      bus.flush_asid  = '0;
      bus.tag_valid   = '0;
      bus.tag_global  = '0;
      bus.tag_asid    = '0;
      bus.tag_vpn     = '0;
      test_reset();
      test_single_global();
      test_single_asid();
      test_walk_all();
      test_walk_asid();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
